// File: rtl/pipelined_rca_if.sv
// pipelined_rca_if: operand/result handshake bundle for the pipelined adder
interface pipelined_rca_if #(parameter int N = 16) ();
    logic         in_valid, in_ready, ci, sub;
    logic         out_valid, out_ready, co, v;
    logic [N-1:0] a, b, s;
    modport master (output in_valid, a, b, ci, sub, out_ready,
                    input  in_ready, out_valid, s, co, v);
    modport slave  (input  in_valid, a, b, ci, sub, out_ready,
                    output in_ready, out_valid, s, co, v);
endinterface

// File: rtl/pipelined_rca.sv
// pipelined_rca: N-bit ripple-carry add/subtract split into STAGES registered slices
// with a global valid/ready stall; results leave fully aligned.
module pipelined_rca #(
    parameter int N      = 16,
    parameter int STAGES = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    pipelined_rca_if.slave io
);
    localparam int W = N / STAGES;
    typedef struct packed {
        logic         vld;
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N-1:0] s;
        logic         c;
        logic         ov;
    } stg_t;
    stg_t       stg_q [STAGES];
    stg_t       stg_d [STAGES];
    stg_t       in_stg, cur;
    logic [W:0] sl;
    logic       adv;
    assign adv    = !stg_q[STAGES-1].vld | io.out_ready;
    assign in_stg = '{vld: io.in_valid, a: io.a, b: io.sub ? ~io.b : io.b,
                      s: '0, c: io.sub | io.ci, ov: 1'b0};
    // Stage i adds slice i using the carry left by slice i-1; ov is only meaningful
    // in the last stage, where sl[W-1] is the MSB of the sum.
    always_comb begin
        cur = '0;
        sl  = '0;
        for (int i = 0; i < STAGES; i++) begin
            cur = (i == 0) ? in_stg : stg_q[(i == 0) ? 0 : i - 1];
            sl  = {1'b0, cur.a[i*W +: W]} + {1'b0, cur.b[i*W +: W]} + (W+1)'(cur.c);
            stg_d[i]             = cur;
            stg_d[i].s[i*W +: W] = sl[W-1:0];
            stg_d[i].c           = sl[W];
            stg_d[i].ov          = sl[W] ^ cur.a[N-1] ^ cur.b[N-1] ^ sl[W-1];
        end
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            for (int i = 0; i < STAGES; i++) stg_q[i] <= '0;
        else if (adv)
            for (int i = 0; i < STAGES; i++) stg_q[i] <= stg_d[i];
    assign io.in_ready  = adv;
    assign io.out_valid = stg_q[STAGES-1].vld;
    assign io.s         = stg_q[STAGES-1].s;
    assign io.co        = stg_q[STAGES-1].c;
    assign io.v         = stg_q[STAGES-1].ov;
endmodule
